// File: rtl/arm_multi_pkg.sv
// rtl/arm_multi_pkg.sv - shared state codes and datapath mux-select constants
//
// Purpose: state encoding for the multicycle main FSM and the select values
//          it drives into the datapath muxes. The datapath decodes with the
//          same constants.
// Ports:   none (package)
package arm_multi_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  // Instruction class, Instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // ALU A select
  localparam logic [1:0] SRCA_REG = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;

  // ALU B select
  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/main_fsm_if.sv
// rtl/main_fsm_if.sv - control bundle between the main FSM and the datapath
//
// Purpose: groups the instruction fields fed to the FSM and the control
//          strobes/selects it returns.
// Signals: Op, Funct (datapath -> FSM); IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
//          ResultSrc, NextPC, RegW, MemW, Branch, ALUOp, State (FSM -> datapath)
// Modports: master = FSM side, slave = datapath side.
interface main_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       ALUOp;
  logic [3:0] State;

  modport master (
    input  Op, Funct,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           NextPC, RegW, MemW, Branch, ALUOp, State
  );

  modport slave (
    output Op, Funct,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
           NextPC, RegW, MemW, Branch, ALUOp, State
  );
endinterface

// File: rtl/flopr.sv
// rtl/flopr.sv - resettable D register
//
// Purpose: WIDTH-bit register, synchronous active-high reset to zero.
// Ports:   clk, reset, d (next value), q (registered value)
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/main_fsm.sv
// rtl/main_fsm.sv - multicycle processor main control FSM
//
// Purpose: Moore FSM sequencing fetch/decode/execute for the multicycle core.
//          All control outputs are a function of the current state only.
// Ports:   clk   - clock
//          reset - synchronous active-high reset, forces FETCH
//          bus   - main_fsm_if.master: Op/Funct in, control strobes,
//                  mux selects and State out
module main_fsm
  import arm_multi_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  main_fsm_if.master    bus
);

  logic [3:0] state_q;
  state_t     next_state;

  // FETCH is code 0, so the register's zero reset lands in FETCH.
  flopr #(.WIDTH(4)) u_state (
    .clk   (clk),
    .reset (reset),
    .d     (next_state),
    .q     (state_q)
  );

  // Op/Funct are only looked at in DECODE and MEMADR.
  always_comb begin
    next_state = FETCH;
    case (state_q)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (bus.Op)
          OP_MEM:  next_state = MEMADR;
          OP_DP:   next_state = bus.Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   next_state = BRANCH;
          default: next_state = UNKNOWN;
        endcase
      end
      MEMADR:   next_state = bus.Funct[0] ? MEMRD : MEMWR;
      MEMRD:    next_state = MEMWB;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      // MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN and codes 11-15 all retire.
      default:  next_state = FETCH;
    endcase
  end

  always_comb begin
    bus.IRWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = SRCA_REG;
    bus.ALUSrcB   = SRCB_WD;
    bus.ResultSrc = RES_ALUOUT;
    bus.NextPC    = 1'b0;
    bus.RegW      = 1'b0;
    bus.MemW      = 1'b0;
    bus.Branch    = 1'b0;
    bus.ALUOp     = 1'b0;
    case (state_q)
      FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        bus.NextPC    = 1'b1;
      end
      DECODE: begin
        // PC+4 again here, so R15 reads as PC+8.
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
      end
      MEMADR: begin
        bus.ALUSrcB = SRCB_IMM;
      end
      MEMRD: begin
        bus.AdrSrc = 1'b1;
      end
      MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegW      = 1'b1;
      end
      MEMWR: begin
        bus.AdrSrc = 1'b1;
        bus.MemW   = 1'b1;
      end
      EXECUTER: begin
        bus.ALUOp = 1'b1;
      end
      EXECUTEI: begin
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = 1'b1;
      end
      ALUWB: begin
        bus.RegW = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcB   = SRCB_IMM;
        bus.ResultSrc = RES_ALURESULT;
        bus.Branch    = 1'b1;
      end
      // UNKNOWN and codes 11-15 keep every output at zero.
      default: ;
    endcase
  end

  assign bus.State = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// tb/tb_main_fsm.sv - scoreboard bench for main_fsm
module tb_main_fsm;

  typedef int path_t[$];

  logic clk = 1'b0;
  logic reset;
  main_fsm_if bus();

  main_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [16:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  // State sequence of one instruction, FETCH to last state before the next FETCH.
  function automatic path_t ref_path(input logic [1:0] op, input logic [5:0] funct);
    path_t p;
    p = '{0, 1};
    case (op)
      2'b01: begin
        p.push_back(2);
        if (funct[0]) begin p.push_back(3); p.push_back(4); end
        else          p.push_back(5);
      end
      2'b00: begin
        p.push_back(funct[5] ? 7 : 6);
        p.push_back(8);
      end
      2'b10:   p.push_back(9);
      default: p.push_back(10);
    endcase
    return p;
  endfunction

  // Output row: {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp}
  function automatic logic [12:0] ref_row(input int s);
    case (s)
      0:       return {1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      1:       return {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      2:       return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      3:       return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      4:       return {1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      5:       return {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      6:       return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      7:       return {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      8:       return {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      9:       return {1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      default: return 13'd0;
    endcase
  endfunction

  function automatic logic [16:0] ref_entry(input int s);
    logic [3:0] sc;
    sc = s[3:0];
    return {sc, ref_row(s)};
  endfunction

  // Entered just after a rising edge with the DUT in FETCH; leaves it the same way.
  // abort_at >= 0 raises reset during that cycle of the instruction.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input int abort_at);
    path_t p;
    p = ref_path(op, funct);
    for (int k = 0; k < p.size(); k++) begin
      exp_q.push_back(ref_entry(p[k]));
      if (p[k] == 1 || p[k] == 2) begin
        bus.Op    = op;
        bus.Funct = funct;
      end else begin
        bus.Op    = 2'($urandom);
        bus.Funct = 6'($urandom);
      end
      if (k == abort_at) reset = 1'b1;
      @(posedge clk);
      #1;
      if (reset) begin
        reset = 1'b0;
        return;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [16:0] e;
    logic [12:0] act;
    if (mon_en) begin
      cyc++;
      act = {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
             bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.ALUOp};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL underflow cyc=%0d: no expected entry, State=%0d", cyc, bus.State);
      end else begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.State !== e[16:13]) begin
          n_bad++;
          $display("FAIL state cyc=%0d: got %0d want %0d", cyc, bus.State, e[16:13]);
        end
        n_cmp++;
        if (act !== e[12:0]) begin
          n_bad++;
          $display("FAIL outputs cyc=%0d state=%0d: got %b want %b", cyc, e[16:13], act, e[12:0]);
        end
      end
    end
  end

  initial begin
    int ab;
    logic [1:0] rop;
    logic [5:0] rfn;
    path_t rp;
    reset     = 1'b1;
    bus.Op    = 2'b11;
    bus.Funct = 6'h3f;
    // Reset held: FETCH row from the first edge onward.
    @(posedge clk); #1;
    exp_q.push_back(ref_entry(0));
    mon_en = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(ref_entry(0));
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(2'b00, 6'b000000, -1);
    run_instr(2'b01, 6'b011001, -1);
    run_instr(2'b01, 6'b011000, -1);
    run_instr(2'b00, 6'b101000, -1);
    run_instr(2'b10, 6'($urandom), -1);
    run_instr(2'b11, 6'($urandom), -1);
    run_instr(2'b01, 6'b011001, 3);
    run_instr(2'b00, 6'b000000, -1);
    run_instr(2'b01, 6'b011001, 0);
    run_instr(2'b11, 6'b111111, -1);

    for (int i = 0; i < 300; i++) begin
      rop = 2'($urandom);
      rfn = 6'($urandom);
      rp  = ref_path(rop, rfn);
      ab  = ($urandom_range(7, 0) == 0) ? int'($urandom_range(rp.size() - 1, 0)) : -1;
      run_instr(rop, rfn, ab);
    end

    mon_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
